// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared definitions for the memory port arbiter.
//   - FSM state codes (IDLE, ISSUE, WAIT, RESP)
//   - requester identifiers (PORT_I fetch, PORT_D load/store)
//   - RV32I funct3 width/sign codes
//   - is_aligned(): legality and alignment check of a funct3/address pair
package mem_arb_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Returns 1 when the access may go to memory. Codes 011/110/111 have no
  // RV32I load/store meaning and are rejected outright, before the width
  // test (110 would otherwise look like a word access).
  function automatic logic is_aligned(input logic [2:0] funct3,
                                      input logic [1:0] addr_lo);
    logic ok;
    if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) begin
      ok = 1'b0;
    end else if (funct3[1:0] == 2'b10) begin
      ok = (addr_lo == 2'b00);
    end else if (funct3[1:0] == 2'b01) begin
      ok = ~addr_lo[0];
    end else begin
      ok = 1'b1;
    end
    return ok;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundle of the fetch port, the load/store port and the
// memory-side port of the arbiter.
//   slave  modport: the arbiter's view
//   master modport: the requesters' and memory's view
//
// Handshake: a requester raises <p>_req with stable address/controls and holds
// them until <p>_ack. <p>_ack is a single-cycle pulse; <p>_rdata and <p>_err
// are meaningful only while <p>_ack=1 and are 0 otherwise. A req dropped
// before it is granted is never served; once granted, the access completes
// and acks even if req has since been dropped.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ack;
  logic [DATA_W-1:0] i_rdata;
  logic              i_err;

  logic              d_req;
  logic              d_wren;
  logic [2:0]        d_funct3;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;
  logic              d_err;

  logic [ADDR_W-1:0] mem_addr;
  logic [2:0]        mem_funct3;
  logic              mem_wren;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_wren, d_funct3, d_addr, d_wdata, mem_rdata,
    output i_ack, i_rdata, i_err, d_ack, d_rdata, d_err,
           mem_addr, mem_funct3, mem_wren, mem_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_wren, d_funct3, d_addr, d_wdata, mem_rdata,
    input  i_ack, i_rdata, i_err, d_ack, d_rdata, d_err,
           mem_addr, mem_funct3, mem_wren, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter_rr.sv
// rr_arbiter2: two-input round-robin grant.
//   req_i/req_d : pending requests
//   take        : the proposed grant is accepted this cycle
//   grant_valid : at least one request pending
//   grant_port  : proposed winner; on a tie, the port not granted last time
// last_grant resets to PORT_D so the fetch port wins the first tie.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic  clk,
  input  logic  reset_n,
  input  logic  req_i,
  input  logic  req_d,
  input  logic  take,
  output logic  grant_valid,
  output port_t grant_port
);
  port_t last_q, last_d;

  always_comb begin
    grant_valid = req_i | req_d;
    if (req_i && req_d) begin
      grant_port = (last_q == PORT_D) ? PORT_I : PORT_D;
    end else if (req_i) begin
      grant_port = PORT_I;
    end else begin
      grant_port = PORT_D;
    end
  end

  always_comb begin
    last_d = last_q;
    if (take) begin
      last_d = grant_port;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q <= PORT_D;
    end else begin
      last_q <= last_d;
    end
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the unified memory's data-side port between the
// fetch unit (port I) and the load/store unit (port D). One transaction at a
// time, round-robin on ties, misaligned/illegal accesses answered without
// touching memory, fixed memory read latency hidden behind the ack.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus          : I/D request ports and memory port (see mem_port_arbiter_if)
//   busy         : high whenever the FSM is not idle
//   state_dbg    : current FSM state code
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_READ_LATENCY = 1,
  parameter int ADDR_W           = 32,
  parameter int DATA_W           = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  mem_port_arbiter_if.slave   bus,
  output logic                busy,
  output logic [1:0]          state_dbg
);
  localparam logic [2:0] LAST_CNT = 3'(MEM_READ_LATENCY - 1);

  logic [1:0]        state_q, state_d;
  port_t             winner_q, winner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        funct3_q, funct3_d;
  logic              wren_q, wren_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [2:0]        cnt_q, cnt_d;

  logic              grant_valid;
  port_t             grant_port;
  logic              take;
  logic [ADDR_W-1:0] sel_addr;
  logic [2:0]        sel_funct3;
  logic              sel_wren;
  logic [DATA_W-1:0] sel_wdata;
  logic              resp;

  assign take = (state_q == ST_IDLE) && grant_valid;

  rr_arbiter2 u_rr (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_i      (bus.i_req),
    .req_d      (bus.d_req),
    .take       (take),
    .grant_valid(grant_valid),
    .grant_port (grant_port)
  );

  // Winner's request fields; a fetch is always a plain word read.
  always_comb begin
    sel_addr   = bus.d_addr;
    sel_funct3 = bus.d_funct3;
    sel_wren   = bus.d_wren;
    sel_wdata  = bus.d_wdata;
    if (grant_port == PORT_I) begin
      sel_addr   = bus.i_addr;
      sel_funct3 = F3_LW;
      sel_wren   = 1'b0;
      sel_wdata  = '0;
    end
  end

  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    addr_d   = addr_q;
    funct3_d = funct3_q;
    wren_d   = wren_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          winner_d = grant_port;
          addr_d   = sel_addr;
          funct3_d = sel_funct3;
          wren_d   = sel_wren;
          wdata_d  = sel_wdata;
          // Cleared here so stores and errors answer with rdata=0.
          rdata_d  = '0;
          cnt_d    = '0;
          err_d    = ~is_aligned(sel_funct3, sel_addr[1:0]);
          state_d  = err_d ? ST_RESP : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = wren_q ? ST_RESP : ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == LAST_CNT) begin
          rdata_d = bus.mem_rdata;
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      winner_q <= PORT_I;
      addr_q   <= '0;
      funct3_q <= '0;
      wren_q   <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
      addr_q   <= addr_d;
      funct3_q <= funct3_d;
      wren_q   <= wren_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  // Outputs decode straight from state, so an asynchronous reset clears them
  // (including mem_wren) without waiting for a clock edge.
  always_comb begin
    bus.mem_addr   = '0;
    bus.mem_funct3 = '0;
    bus.mem_wren   = 1'b0;
    bus.mem_wdata  = '0;
    if (state_q == ST_ISSUE || state_q == ST_WAIT) begin
      bus.mem_addr   = addr_q;
      bus.mem_funct3 = funct3_q;
    end
    if (state_q == ST_ISSUE) begin
      bus.mem_wdata = wdata_q;
      bus.mem_wren  = wren_q;
    end
    resp        = (state_q == ST_RESP);
    bus.i_ack   = resp && (winner_q == PORT_I);
    bus.d_ack   = resp && (winner_q == PORT_D);
    bus.i_rdata = bus.i_ack ? rdata_q : '0;
    bus.i_err   = bus.i_ack & err_q;
    bus.d_rdata = bus.d_ack ? rdata_q : '0;
    bus.d_err   = bus.d_ack & err_q;
  end

  assign busy      = (state_q != ST_IDLE);
  assign state_dbg = state_q;
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single data-side port of the unified instruction/data memory between two requesters:
  - the fetch unit (port I: read-only, word access);
  - the load/store unit (port D: lb/lh/lw/lbu/lhu/sb/sh/sw).
- Sits between the processor control state machine and the memory module.
- Serialises accesses with a req/ack handshake and hides the memory's fixed read latency.
- Round-robin arbitration, alignment checking, one outstanding transaction at a time.

Parameters:
- MEM_READ_LATENCY, 1, clock cycles from address presented to mem_rdata valid (legal 1..4)
- ADDR_W, 32, address width
- DATA_W, 32, data width

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset_n  input  1  asynchronous active-low reset
- i_req  input  1  fetch request, held until i_ack
- i_addr  input  ADDR_W  fetch byte address
- i_ack  output  1  one-cycle pulse, fetch complete
- i_rdata  output  DATA_W  fetched word, valid while i_ack=1
- i_err  output  1  misaligned fetch, valid while i_ack=1
- d_req  input  1  load/store request, held until d_ack
- d_wren  input  1  1=store, 0=load
- d_funct3  input  3  RV32I width/sign code
- d_addr  input  ADDR_W  data byte address
- d_wdata  input  DATA_W  store data
- d_ack  output  1  one-cycle pulse, data access complete
- d_rdata  output  DATA_W  load result, valid while d_ack=1
- d_err  output  1  misaligned or illegal funct3, valid while d_ack=1
- mem_addr  output  ADDR_W  to memory address input
- mem_funct3  output  3  to memory funct3
- mem_wren  output  1  to memory write enable
- mem_wdata  output  DATA_W  to memory data input
- mem_rdata  input  DATA_W  from memory data output
- busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, last_grant=D (so I wins first tie).
  - All outputs 0; latched address/data registers 0.
  - Reset mid-transaction aborts it: no ack, and mem_wren drops immediately.
- States: IDLE -> ISSUE -> (WAIT, loads/fetches only) -> RESP -> IDLE. The ERR path is IDLE -> RESP.
- IDLE:
  - Only i_req: grant I. Only d_req: grant D. Both: grant the port not in last_grant.
  - On grant, latch addr/funct3/wren/wdata and the winner, then update last_grant.
  - Fetch always uses funct3=3'b010, wren=0.
  - Alignment check on latched values:
    - word (funct3[1:0]=10) requires addr[1:0]=0;
    - half (x01) requires addr[0]=0;
    - funct3 of 011, 110 or 111 is illegal.
  - Error: go straight to RESP with err=1, rdata=0, no memory access, mem_wren never asserted.
  - Otherwise go to ISSUE.
- ISSUE (1 cycle):
  - mem_addr/mem_funct3/mem_wdata driven from latched registers.
  - mem_wren=1 only in this cycle and only for a store.
  - Store: next state RESP. Read: next state WAIT, counter=0.
- WAIT:
  - mem_addr/mem_funct3 held, mem_wren=0, counter increments each cycle.
  - When counter=MEM_READ_LATENCY-1, capture mem_rdata into the rdata register and go to RESP.
- RESP (1 cycle):
  - Winner's ack=1, with rdata/err driven from registers.
  - The other port's ack=0, rdata=0, err=0.
  - Next state IDLE.
- mem_* outputs are 0 in IDLE and RESP.
- Latency from req sampled in IDLE to ack:
  - store: 2 cycles;
  - read: 2+MEM_READ_LATENCY cycles;
  - error: 1 cycle.
- A new grant is possible in the cycle after RESP; no back-to-back grant out of RESP.
- A requester that drops req before grant is simply not served. After grant, the transaction completes and acks regardless of req.
- Request inputs are sampled only in IDLE; changes in other states are ignored.
- Stores return d_rdata=0.
- d_funct3 sign/zero extension is performed by the memory, not here.

Decomposition:
- Shared package mem_arb_pkg:
  - state enum (IDLE, ISSUE, WAIT, RESP);
  - port-id enum (PORT_I, PORT_D);
  - funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW);
  - function is_aligned(funct3, addr[1:0]).
- One sub-module is natural: rr_arbiter2, a 2-input round-robin grant with last_grant state.

Test Plan:
- Lone fetch, i_addr=0x1000, mem returns 0x00500093, L=1 -> i_ack at cycle 3, i_rdata=0x00500093, i_err=0, d_ack stays 0.
- Lone store sw, d_addr=0x2004, d_wdata=0xDEADBEEF -> mem_wren=1 for exactly the cycle-1 ISSUE with mem_addr=0x2004 and mem_wdata=0xDEADBEEF, d_ack at cycle 2.
- i_req and d_req both held continuously -> grants alternate I,D,I,D; each ack is one cycle, with no overlap and no starvation over 8 transactions.
- lw at 0x2002, then lh at 0x2001 -> d_ack after 1 cycle with d_err=1 and mem_wren never 1; lh at 0x2002 succeeds with d_err=0.
- MEM_READ_LATENCY=3, load at 0x2000 -> mem_addr held 4 cycles (ISSUE + 3 WAIT), d_ack at cycle 5 with the captured data.
- reset_n pulled low during WAIT of a fetch -> outputs 0 asynchronously, no i_ack; after release, a held i_req is served normally with I winning the first tie.
